// File: rtl/flash_line_buffer_pkg.sv
// Shared configuration and encodings for the flash read line buffer.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef MAX_BIT_POS
`define MAX_BIT_POS (`XLEN-1)
`endif

package flash_line_buffer_pkg;

   typedef enum logic [2:0] {
      FLB_IDLE     = 3'd0,
      FLB_FILL_REQ = 3'd1,
      FLB_FILL_GAP = 3'd2,
      FLB_WR_REQ   = 3'd3,
      FLB_RESP     = 3'd4
   } flb_state_t;

   localparam logic [1:0] FLB_SIZE_WORD = 2'd0;

endpackage

// File: rtl/flash_line_store.sv
// One-line storage: word array, line tag and valid bit, with a combinational
// read port and tag/hit compare against the incoming request.
module flash_line_store
   import flash_line_buffer_pkg::*;
#(
   parameter int LINE_WORDS = 4,
   parameter int IDX_W      = 2,
   parameter int TAG_W      = 28
) (
   input  logic              flashclk,
   input  logic              rst,
   input  logic              i_we,
   input  logic [IDX_W-1:0]  i_widx,
   input  logic [`XLEN-1:0]  i_wdata,
   input  logic              i_tag_we,
   input  logic [TAG_W-1:0]  i_tag,
   input  logic              i_valid_set,
   input  logic              i_valid_clr,
   input  logic [IDX_W-1:0]  i_ridx,
   output logic [`XLEN-1:0]  o_rdata,
   input  logic [TAG_W-1:0]  i_cmp_tag,
   output logic              o_tag_eq,
   output logic              o_hit
);

   logic [`XLEN-1:0] r_line [LINE_WORDS];
   logic [TAG_W-1:0] r_tag;
   logic             r_valid;

   always_ff @(posedge flashclk) begin
      if (i_we) begin
         r_line[i_widx] <= i_wdata;
      end
   end

   // Clear wins over set so an invalidating event is never lost.
   always_ff @(posedge flashclk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_tag   <= '0;
      end else begin
         if (i_valid_clr) begin
            r_valid <= 1'b0;
         end else if (i_valid_set) begin
            r_valid <= 1'b1;
         end
         if (i_tag_we) begin
            r_tag <= i_tag;
         end
      end
   end

   assign o_rdata  = r_line[i_ridx];
   assign o_tag_eq = (r_tag == i_cmp_tag);
   assign o_hit    = r_valid & o_tag_eq;

endmodule

// File: rtl/flash_line_buffer.sv
// Single-line read buffer in front of the byte-serial flash adapter, refilling
// critical word first with early restart; writes pass through and invalidate.
module flash_line_buffer
   import flash_line_buffer_pkg::*;
#(
   parameter int LINE_WORDS = 4
) (
   input  logic              flashclk,
   input  logic              rst,
   input  logic [`XLEN-1:0]  fetch_addr,
   input  logic              fetch_read,
   input  logic              fetch_write,
   input  logic [`XLEN-1:0]  fetch_wdata,
   input  logic [1:0]        fetch_byte_size,
   output logic [`XLEN-1:0]  fetch_rdata,
   output logic              fetch_ready,
   output logic [`XLEN-1:0]  flash_io_addr,
   output logic              flash_io_read,
   output logic              flash_io_write,
   output logic [`XLEN-1:0]  flash_io_wdata,
   output logic [1:0]        io_byte_size,
   input  logic [`XLEN-1:0]  flash_io_rdata,
   input  logic              flash_io_ready
);

   localparam int IDX_W = $clog2(LINE_WORDS);
   localparam int TAG_W = `XLEN - IDX_W - 2;

   flb_state_t       r_state;
   logic [`XLEN-1:0] r_base;
   logic [IDX_W-1:0] r_fill_idx;
   logic [IDX_W-1:0] r_crit_idx;
   logic [IDX_W:0]   r_words_left;
   logic             r_served;

   logic [IDX_W-1:0] w_idx;
   logic [TAG_W-1:0] w_tag;
   logic [`XLEN-1:0] w_base;
   logic [`XLEN-1:0] w_fill_off;
   logic [`XLEN-1:0] w_rdata;
   logic             w_hit;
   logic             w_tag_eq;
   logic             w_wr_req;
   logic             w_miss;
   logic             w_fill_ack;
   logic             w_last;

   assign w_idx      = fetch_addr[IDX_W+1:2];
   assign w_tag      = fetch_addr[`MAX_BIT_POS:IDX_W+2];
   assign w_base     = {w_tag, {(IDX_W+2){1'b0}}};
   assign w_fill_off = {{(`XLEN-IDX_W-2){1'b0}}, r_fill_idx, 2'b00};
   assign w_wr_req   = (r_state == FLB_IDLE) && fetch_write;
   assign w_miss     = (r_state == FLB_IDLE) && !fetch_write && fetch_read && !w_hit;
   assign w_fill_ack = (r_state == FLB_FILL_REQ) && flash_io_ready;
   assign w_last     = w_fill_ack && (r_words_left == (IDX_W+1)'(1));

   flash_line_store #(
      .LINE_WORDS (LINE_WORDS),
      .IDX_W      (IDX_W),
      .TAG_W      (TAG_W)
   ) u_store (
      .flashclk    (flashclk),
      .rst         (rst),
      .i_we        (w_fill_ack),
      .i_widx      (r_fill_idx),
      .i_wdata     (flash_io_rdata),
      .i_tag_we    (w_miss),
      .i_tag       (w_tag),
      .i_valid_set (w_last),
      .i_valid_clr (w_miss || (w_wr_req && w_tag_eq)),
      .i_ridx      (w_idx),
      .o_rdata     (w_rdata),
      .i_cmp_tag   (w_tag),
      .o_tag_eq    (w_tag_eq),
      .o_hit       (w_hit)
   );

   always_ff @(posedge flashclk) begin
      if (rst) begin
         r_state        <= FLB_IDLE;
         r_base         <= '0;
         r_fill_idx     <= '0;
         r_crit_idx     <= '0;
         r_words_left   <= '0;
         r_served       <= 1'b0;
         fetch_rdata    <= '0;
         fetch_ready    <= 1'b0;
         flash_io_addr  <= '0;
         flash_io_read  <= 1'b0;
         flash_io_write <= 1'b0;
         flash_io_wdata <= '0;
         io_byte_size   <= '0;
      end else begin
         fetch_ready <= 1'b0;
         case (r_state)
            FLB_IDLE: begin
               if (fetch_write) begin
                  flash_io_write <= 1'b1;
                  flash_io_addr  <= fetch_addr;
                  flash_io_wdata <= fetch_wdata;
                  io_byte_size   <= fetch_byte_size;
                  r_state        <= FLB_WR_REQ;
               end else if (fetch_read) begin
                  if (w_hit) begin
                     fetch_rdata <= w_rdata;
                     fetch_ready <= 1'b1;
                     r_state     <= FLB_RESP;
                  end else begin
                     // Fill starts at the requested word and wraps around the line.
                     r_base        <= w_base;
                     r_fill_idx    <= w_idx;
                     r_crit_idx    <= w_idx;
                     r_words_left  <= (IDX_W+1)'(LINE_WORDS);
                     r_served      <= 1'b0;
                     flash_io_read <= 1'b1;
                     flash_io_addr <= {fetch_addr[`MAX_BIT_POS:2], 2'b00};
                     io_byte_size  <= FLB_SIZE_WORD;
                     r_state       <= FLB_FILL_REQ;
                  end
               end
            end
            FLB_FILL_REQ: begin
               if (flash_io_ready) begin
                  flash_io_read <= 1'b0;
                  r_fill_idx    <= r_fill_idx + 1'b1;
                  r_words_left  <= r_words_left - 1'b1;
                  if ((r_fill_idx == r_crit_idx) && !r_served) begin
                     fetch_rdata <= flash_io_rdata;
                     fetch_ready <= 1'b1;
                     r_served    <= 1'b1;
                  end
                  r_state <= w_last ? FLB_RESP : FLB_FILL_GAP;
               end
            end
            FLB_FILL_GAP: begin
               flash_io_read <= 1'b1;
               flash_io_addr <= r_base + w_fill_off;
               r_state       <= FLB_FILL_REQ;
            end
            FLB_WR_REQ: begin
               if (flash_io_ready) begin
                  flash_io_write <= 1'b0;
                  fetch_ready    <= 1'b1;
                  r_state        <= FLB_RESP;
               end
            end
            FLB_RESP: begin
               r_state <= FLB_IDLE;
            end
            default: begin
               r_state <= FLB_IDLE;
            end
         endcase
      end
   end

endmodule
